// File: rtl/counter_share_arbiter.sv
// Round-robin arbiter sharing one free-running counter between NREQ requesters.
// Each request walks GRANT -> EXEC -> RESP and returns exactly one response.
module counter_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int OUT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     free_en,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [OUT_W-1:0]         cnt_out,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [OUT_W-1:0] cnt_out_q;

    logic [1:0]       op_arr   [NREQ];
    logic [WIDTH-1:0] data_arr [NREQ];
    logic             found;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   scan_idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_arr[g]   = req_op[2*g +: 2];
        assign data_arr[g] = req_data[WIDTH*g +: WIDTH];
    end

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = IDW'((int'(rr_ptr_q) + i) % NREQ);
            if (!found && req_valid[scan_idx]) begin
                found   = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        op_d       = op_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        cnt_d      = free_en ? cnt_q + WIDTH'(1) : cnt_q;
        req_ready  = '0;

        unique case (state_q)
            IDLE: begin
                if (|req_valid) state_d = GRANT;
            end
            GRANT: begin
                if (found) begin
                    req_ready[gnt_idx] = 1'b1;
                    id_d     = gnt_idx;
                    op_d     = op_arr[gnt_idx];
                    data_d   = data_arr[gnt_idx];
                    rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
                    state_d  = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                unique case (op_q)
                    OP_READ:  cnt_d = free_en ? cnt_q + WIDTH'(1) : cnt_q;
                    OP_INC:   cnt_d = cnt_q + data_q;
                    OP_LOAD:  cnt_d = data_q;
                    OP_CLEAR: cnt_d = '0;
                    default:  cnt_d = cnt_q;
                endcase
                // READ reports the value before this cycle's free increment.
                rsp_data_d = (op_q == OP_READ) ? cnt_q : cnt_d;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            op_q       <= OP_READ;
            data_q     <= '0;
            rsp_data_q <= '0;
            cnt_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            op_q       <= op_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            cnt_out_q  <= cnt_q[OUT_W-1:0];
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign cnt_out   = cnt_out_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Directed self-checking bench for counter_share_arbiter.
// Inputs change and outputs are checked on the falling clock edge.
module tb_counter_share_arbiter;

    localparam logic [1:0] READ  = 2'b00;
    localparam logic [1:0] INC   = 2'b01;
    localparam logic [1:0] LOAD  = 2'b10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         free_en;
    logic [3:0]   req_valid;
    logic [7:0]   req_op;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic [15:0]  cnt_out;
    logic         busy;

    int checks = 0;
    int errors = 0;

    counter_share_arbiter #(.NREQ(4), .WIDTH(32), .OUT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .free_en   (free_en),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .cnt_out   (cnt_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request from IDLE; returns on the EXEC falling edge.
    task automatic issue(input int g, input logic [1:0] op,
                         input logic [31:0] d);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        req_valid[g]         = 1'b1;
        req_op[2*g +: 2]     = op;
        req_data[32*g +: 32] = d;
        @(negedge clk);
        chk("grant_ready", 32'(req_ready), 32'(oh));
        chk("grant_busy", 32'(busy), 32'd1);
        @(negedge clk);
        req_valid[g] = 1'b0;
        chk("exec_ready", 32'(req_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        free_en   = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cnt_out", 32'(cnt_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);

        // Free run after release: cnt_out lags the counter by one cycle.
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("free_run", 32'(cnt_out), 32'(i));
        end
        chk("free_busy", 32'(busy), 32'd0);
        free_en = 1'b0;

        // Single LOAD.
        issue(0, LOAD, 32'h0001_FFFE);
        chk("load_exec_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("load_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("load_rsp_id", 32'(rsp_id), 32'd0);
        chk("load_rsp_data", rsp_data, 32'h0001_FFFE);
        @(negedge clk);
        chk("load_done_valid", 32'(rsp_valid), 32'd0);
        chk("load_cnt_out", 32'(cnt_out), 32'h0000_FFFE);
        chk("load_done_busy", 32'(busy), 32'd0);

        // Request withdrawn before GRANT samples it.
        req_valid[1] = 1'b1;
        @(negedge clk);
        chk("drop_busy", 32'(busy), 32'd1);
        req_valid[1] = 1'b0;
        #1;
        chk("drop_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("drop_idle", 32'(busy), 32'd0);

        // INC with free run enabled: no extra +1 in EXEC.
        issue(0, LOAD, 32'd10);
        @(negedge clk);
        chk("ld10_rsp", rsp_data, 32'd10);
        @(negedge clk);
        issue(2, INC, 32'd5);
        free_en = 1'b1;
        @(negedge clk);
        chk("inc_rsp_data", rsp_data, 32'd15);
        chk("inc_rsp_id", 32'(rsp_id), 32'd2);
        @(negedge clk);
        chk("inc_cnt_out15", 32'(cnt_out), 32'd15);
        @(negedge clk);
        chk("inc_cnt_out16", 32'(cnt_out), 32'd16);
        free_en = 1'b0;

        // Back-pressure: response held, no new grant.
        rsp_ready = 1'b0;
        issue(1, READ, 32'd0);
        req_valid[3] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_data", rsp_data, 32'd17);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_done", 32'(rsp_valid), 32'd0);
        req_valid[3] = 1'b0;

        // Asynchronous reset in EXEC of a LOAD.
        issue(0, LOAD, 32'hDEAD_BEEF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_req_ready", 32'(req_ready), 32'd0);
        chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ar_rsp_id", 32'(rsp_id), 32'd0);
        chk("ar_rsp_data", rsp_data, 32'd0);
        chk("ar_cnt_out", 32'(cnt_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ar_no_rsp", 32'(rsp_valid), 32'd0);
            chk("ar_idle", 32'(busy), 32'd0);
        end

        // Wrap boundaries: 32-bit INC and 16-bit cnt_out.
        issue(0, LOAD, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("wrap_load", rsp_data, 32'hFFFF_FFFF);
        @(negedge clk);
        issue(1, INC, 32'd2);
        @(negedge clk);
        chk("wrap_inc", rsp_data, 32'd1);
        @(negedge clk);
        issue(2, LOAD, 32'h0000_FFFE);
        @(negedge clk);
        free_en = 1'b1;
        @(negedge clk);
        chk("wrap_out_fffe", 32'(cnt_out), 32'h0000_FFFE);
        @(negedge clk);
        chk("wrap_out_ffff", 32'(cnt_out), 32'h0000_FFFF);
        @(negedge clk);
        chk("wrap_out_0000", 32'(cnt_out), 32'h0000_0000);
        free_en = 1'b0;

        // Round robin from a fresh reset, all requesters reading.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        req_op    = '0;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            @(negedge clk);
            chk("rr_exec", 32'(req_ready), 32'd0);
            @(negedge clk);
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_id", 32'(rsp_id), 32'(k % 4));
            chk("rr_data", rsp_data, 32'd0);
            @(negedge clk);
            chk("rr_idle", 32'(busy), 32'd0);
        end
        req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
